control_unit_v2: RTL and testbench
==================================

CONTROL_UNIT_V2 -- requirements
Module: control_unit_v2

Interface
REQ-001 No parameters; state codes are localparams, 5 bits wide.
REQ-002 Clk  in  1  single clock; all state updates on rising edge.
REQ-003 RESET  in  1  synchronous, active-high reset.
REQ-004 IR_Out  in  32  current instruction.
REQ-005 MFC  in  1  memory function complete; MSET in 1 is reserved and ignored.
REQ-006 out_BLA, BA_O, BN_O  in  1 each  branch condition true / branch-always / branch-never from datapath.
REQ-007 S, PS, ET  in  1 each  PSR supervisor, previous-supervisor, enable-traps bits.
REQ-008 IR_enable, PC_enable, NPC_enable, MDR_Enable, MAR_Enable, register_file_enable, RAM_enable, PSR_Enable, TBR_enable  out  1 each  register/memory enables.
REQ-009 PC_Clr, PSR_Clr, TBR_Clr  out  1 each  datapath clears.
REQ-010 in_PA, in_PB, in_PC  out  5 each  register-file read A, read B, write addresses.
REQ-011 ALU_op, RAM_OpCode  out  6 each  ALU operation; memory op (SPARC op3).
REQ-012 tt  out  3  trap type; extender_select out 3; ALUB_Mux_select out 3; PC_In_Mux_select, ALUA_Mux_select, PSR_Mux_select out 2; MDR_Mux_select, TBR_Mux_select out 1.

Function
REQ-013 Outputs SHALL be a combinational decode of the state register and IR_Out; unlisted outputs are 0 in every state.
REQ-014 Default addresses: in_PA=IR[18:14], in_PB=IR[4:0], in_PC=IR[29:25].
REQ-015 Mux encodings: ALUA 0=out_PA, 1=PC, 2=NPC, 3=zero; ALUB 0=out_PB, 1=extender, 2=const 4, 3=MDR, 4=zero; PC_In 0=NPC, 1=ALU_Out, 2=TBR; MDR 0=ALU_Out, 1=RAM; extender 0=simm13 sext, 1=disp22 sext<<2, 2=disp30<<2, 3=imm22<<10; ALU_op 000000=ADD.
REQ-016 States/codes: RESET0, INIT1, FETCH0 2, FETCH1 3, FETCH2 4, DECODE5, ARITH6, SETHI7, BR8, BR_ANNUL9, CALL1 10, CALL2 11, LS_ADDR12, LD_MEM13, LD_WB14, ST_DATA15, ST_MEM16, NEXT_PC17, TRAP18, HALT19.
REQ-017 RESET: PC_Clr, PSR_Clr, TBR_Clr=1 -> INIT. INIT: NPC<-0+4 (ALUA3, ALUB2, ADD, NPC_enable) -> FETCH0.
REQ-018 FETCH0: MAR<-PC+0 -> FETCH1. FETCH1: RAM_enable, RAM_OpCode=000000, MDR_Mux 1, MDR_Enable; hold until MFC=1 -> FETCH2. FETCH2: IR_enable -> DECODE.
REQ-019 DECODE on IR[31:30]: 00 with op2=010 -> BR, op2=100 -> SETHI; 01 -> CALL1; 10 -> ARITH; 11 with op3 in {000000,000100} -> LS_ADDR; anything else -> TRAP.
REQ-020 ARITH: A=out_PA, B=IR[13]?extender(0):out_PB, ALU_op=IR[24:19], register_file_enable; PSR_Enable when IR[23]=1 -> NEXT_PC. SETHI: rd<-0+ext3 -> NEXT_PC.
REQ-021 taken = (out_BLA | BA_O) & !BN_O; annul = IR[29] & (!taken | BA_O).
REQ-022 BR: taken & !annul: PC<-NPC, NPC<-PC+ext1, -> FETCH0; taken & annul: PC<-PC+ext1 (PC_In 1) -> BR_ANNUL; !taken & annul: PC<-NPC+4 (PC_In 1) -> BR_ANNUL; !taken & !annul -> NEXT_PC. BR_ANNUL: NPC<-PC+4 -> FETCH0.
REQ-023 CALL1: r15<-PC+0 (in_PC=15) -> CALL2: PC<-NPC, NPC<-PC+ext2 -> FETCH0.
REQ-024 LS_ADDR: MAR<-rs1+(i?ext0:out_PB); load -> LD_MEM (RAM read, RAM_OpCode=op3, MDR_Enable until MFC) -> LD_WB (rd<-0+MDR) -> NEXT_PC; store -> ST_DATA (in_PB=rd, MDR<-0+out_PB, MDR_Mux 0) -> ST_MEM (RAM_enable, RAM_OpCode=000100 until MFC) -> NEXT_PC.
REQ-025 NEXT_PC: PC<-NPC, NPC<-NPC+4 -> FETCH0.
REQ-026 TRAP: ET=1: tt=3'b010, TBR_Mux 1, TBR_enable, PSR_Mux 1, PSR_Enable (ET<-0, PS<-S, S<-1), PC<-TBR -> INIT-like NPC<-PC+4 via BR_ANNUL; ET=0 -> HALT. HALT holds until RESET.
REQ-027 MFC low in wait states holds state indefinitely with enables asserted.

Reset
REQ-028 RESET=1 at any rising edge forces state RESET regardless of current state, including mid memory wait.
REQ-029 Before first reset, state is undefined; bench SHALL apply RESET >=1 cycle.

Structure
REQ-030 State codes, mux encodings and opcode constants SHALL live in a shared package used by control unit and datapath.
REQ-031 Single module; one state register, one next-state always block, one output decode block; no sub-modules.

Verification
REQ-032 RESET 1 cycle -> PC_Clr=1, then INIT NPC_enable=1, then FETCH0 MAR_Enable=1.
REQ-033 FETCH1 with MFC held 0 for 3 cycles -> state stays 3; MFC=1 -> FETCH2, IR_enable=1.
REQ-034 IR=add r1,r2,r3 (0x86004002... op=10, op3=000000) -> ARITH: ALU_op=000000, in_PC=3, register_file_enable=1, then NEXT_PC.
REQ-035 IR=BA,a=0 -> BR: PC_In 0, NPC_enable, extender_select=1, next FETCH0; BNE,a=1 with out_BLA=0 -> BR_ANNUL.
REQ-036 IR op=00 op2=000 with ET=1 -> TRAP tt=010, PC_In 2; with ET=0 -> HALT stays until RESET.

Source files
------------

// File: rtl/control_unit_v2_pkg.sv
// Shared constants for the multicycle SPARC-subset control unit and its datapath:
// state codes, mux select encodings, opcode fields and branch-condition helpers.
package control_unit_v2_pkg;

    typedef enum logic [4:0] {
        S_RESET    = 5'd0,
        S_INIT     = 5'd1,
        S_FETCH0   = 5'd2,
        S_FETCH1   = 5'd3,
        S_FETCH2   = 5'd4,
        S_DECODE   = 5'd5,
        S_ARITH    = 5'd6,
        S_SETHI    = 5'd7,
        S_BR       = 5'd8,
        S_BR_ANNUL = 5'd9,
        S_CALL1    = 5'd10,
        S_CALL2    = 5'd11,
        S_LS_ADDR  = 5'd12,
        S_LD_MEM   = 5'd13,
        S_LD_WB    = 5'd14,
        S_ST_DATA  = 5'd15,
        S_ST_MEM   = 5'd16,
        S_NEXT_PC  = 5'd17,
        S_TRAP     = 5'd18,
        S_HALT     = 5'd19
    } state_t;

    localparam logic [1:0] ALUA_PA   = 2'd0;
    localparam logic [1:0] ALUA_PC   = 2'd1;
    localparam logic [1:0] ALUA_NPC  = 2'd2;
    localparam logic [1:0] ALUA_ZERO = 2'd3;

    localparam logic [2:0] ALUB_PB   = 3'd0;
    localparam logic [2:0] ALUB_EXT  = 3'd1;
    localparam logic [2:0] ALUB_FOUR = 3'd2;
    localparam logic [2:0] ALUB_MDR  = 3'd3;
    localparam logic [2:0] ALUB_ZERO = 3'd4;

    localparam logic [1:0] PCIN_NPC = 2'd0;
    localparam logic [1:0] PCIN_ALU = 2'd1;
    localparam logic [1:0] PCIN_TBR = 2'd2;

    localparam logic MDR_ALU = 1'b0;
    localparam logic MDR_RAM = 1'b1;

    localparam logic [2:0] EXT_SIMM13 = 3'd0;
    localparam logic [2:0] EXT_DISP22 = 3'd1;
    localparam logic [2:0] EXT_DISP30 = 3'd2;
    localparam logic [2:0] EXT_IMM22  = 3'd3;

    localparam logic [5:0] ALU_ADD = 6'b000000;
    localparam logic [5:0] OP3_LD  = 6'b000000;
    localparam logic [5:0] OP3_ST  = 6'b000100;

    localparam logic [1:0] OP_FMT2  = 2'b00;
    localparam logic [1:0] OP_CALL  = 2'b01;
    localparam logic [1:0] OP_ARITH = 2'b10;
    localparam logic [1:0] OP_MEM   = 2'b11;

    localparam logic [2:0] OP2_BICC  = 3'b010;
    localparam logic [2:0] OP2_SETHI = 3'b100;

    localparam logic [2:0] TT_ILLEGAL   = 3'b010;
    localparam logic       TBR_MUX_TT   = 1'b1;
    localparam logic [1:0] PSR_MUX_TRAP = 2'd1;
    localparam logic [4:0] REG_LINK     = 5'd15;

    function automatic logic br_taken(input logic bla, input logic ba, input logic bn);
        return (bla | ba) & ~bn;
    endfunction

    // The annul bit squashes the delay slot when not taken, and always for branch-always.
    function automatic logic br_annul(input logic a, input logic taken, input logic ba);
        return a & (~taken | ba);
    endfunction

endpackage

// File: rtl/control_unit_v2.sv
// Multicycle control FSM: one state register, a next-state block and a
// combinational output decode of the state and the current instruction.
module control_unit_v2
    import control_unit_v2_pkg::*;
(
    input  logic        Clk,
    input  logic        RESET,
    input  logic [31:0] IR_Out,
    input  logic        MFC,
    input  logic        MSET,
    input  logic        out_BLA,
    input  logic        BA_O,
    input  logic        BN_O,
    input  logic        S,
    input  logic        PS,
    input  logic        ET,
    output logic        IR_enable,
    output logic        PC_enable,
    output logic        NPC_enable,
    output logic        MDR_Enable,
    output logic        MAR_Enable,
    output logic        register_file_enable,
    output logic        RAM_enable,
    output logic        PSR_Enable,
    output logic        TBR_enable,
    output logic        PC_Clr,
    output logic        PSR_Clr,
    output logic        TBR_Clr,
    output logic [4:0]  in_PA,
    output logic [4:0]  in_PB,
    output logic [4:0]  in_PC,
    output logic [5:0]  ALU_op,
    output logic [5:0]  RAM_OpCode,
    output logic [2:0]  tt,
    output logic [2:0]  extender_select,
    output logic [2:0]  ALUB_Mux_select,
    output logic [1:0]  PC_In_Mux_select,
    output logic [1:0]  ALUA_Mux_select,
    output logic [1:0]  PSR_Mux_select,
    output logic        MDR_Mux_select,
    output logic        TBR_Mux_select
);

    state_t state_q, state_d;
    logic   taken, annul;
    logic   unused_ok;

    wire [1:0] op  = IR_Out[31:30];
    wire [2:0] op2 = IR_Out[24:22];
    wire [5:0] op3 = IR_Out[24:19];
    wire       imm = IR_Out[13];

    assign taken     = br_taken(out_BLA, BA_O, BN_O);
    assign annul     = br_annul(IR_Out[29], taken, BA_O);
    assign unused_ok = ^{MSET, S, PS, IR_Out[12:5]};

    always_ff @(posedge Clk) begin
        if (RESET) state_q <= S_RESET;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RESET:  state_d = S_INIT;
            S_INIT:   state_d = S_FETCH0;
            S_FETCH0: state_d = S_FETCH1;
            S_FETCH1: if (MFC) state_d = S_FETCH2;
            S_FETCH2: state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_FMT2: begin
                        if      (op2 == OP2_BICC)  state_d = S_BR;
                        else if (op2 == OP2_SETHI) state_d = S_SETHI;
                        else                       state_d = S_TRAP;
                    end
                    OP_CALL:  state_d = S_CALL1;
                    OP_ARITH: state_d = S_ARITH;
                    default: begin
                        if (op3 == OP3_LD || op3 == OP3_ST) state_d = S_LS_ADDR;
                        else                                state_d = S_TRAP;
                    end
                endcase
            end
            S_ARITH:   state_d = S_NEXT_PC;
            S_SETHI:   state_d = S_NEXT_PC;
            S_BR: begin
                if (taken && !annul) state_d = S_FETCH0;
                else if (annul)      state_d = S_BR_ANNUL;
                else                 state_d = S_NEXT_PC;
            end
            S_BR_ANNUL: state_d = S_FETCH0;
            S_CALL1:    state_d = S_CALL2;
            S_CALL2:    state_d = S_FETCH0;
            S_LS_ADDR:  state_d = (op3 == OP3_LD) ? S_LD_MEM : S_ST_DATA;
            S_LD_MEM:   if (MFC) state_d = S_LD_WB;
            S_LD_WB:    state_d = S_NEXT_PC;
            S_ST_DATA:  state_d = S_ST_MEM;
            S_ST_MEM:   if (MFC) state_d = S_NEXT_PC;
            S_NEXT_PC:  state_d = S_FETCH0;
            // Trap reuses BR_ANNUL to rebuild NPC from the freshly loaded PC.
            S_TRAP:     state_d = ET ? S_BR_ANNUL : S_HALT;
            S_HALT:     state_d = S_HALT;
            default:    state_d = S_RESET;
        endcase
    end

    always_comb begin
        IR_enable            = 1'b0;
        PC_enable            = 1'b0;
        NPC_enable           = 1'b0;
        MDR_Enable           = 1'b0;
        MAR_Enable           = 1'b0;
        register_file_enable = 1'b0;
        RAM_enable           = 1'b0;
        PSR_Enable           = 1'b0;
        TBR_enable           = 1'b0;
        PC_Clr               = 1'b0;
        PSR_Clr              = 1'b0;
        TBR_Clr              = 1'b0;
        in_PA                = IR_Out[18:14];
        in_PB                = IR_Out[4:0];
        in_PC                = IR_Out[29:25];
        ALU_op               = ALU_ADD;
        RAM_OpCode           = '0;
        tt                   = '0;
        extender_select      = EXT_SIMM13;
        ALUB_Mux_select      = ALUB_PB;
        PC_In_Mux_select     = PCIN_NPC;
        ALUA_Mux_select      = ALUA_PA;
        PSR_Mux_select       = '0;
        MDR_Mux_select       = MDR_ALU;
        TBR_Mux_select       = 1'b0;
        case (state_q)
            S_RESET: begin
                PC_Clr  = 1'b1;
                PSR_Clr = 1'b1;
                TBR_Clr = 1'b1;
            end
            S_INIT: begin
                ALUA_Mux_select = ALUA_ZERO;
                ALUB_Mux_select = ALUB_FOUR;
                NPC_enable      = 1'b1;
            end
            S_FETCH0: begin
                ALUA_Mux_select = ALUA_PC;
                ALUB_Mux_select = ALUB_ZERO;
                MAR_Enable      = 1'b1;
            end
            S_FETCH1: begin
                RAM_enable     = 1'b1;
                RAM_OpCode     = OP3_LD;
                MDR_Mux_select = MDR_RAM;
                MDR_Enable     = 1'b1;
            end
            S_FETCH2: IR_enable = 1'b1;
            S_ARITH: begin
                ALUA_Mux_select      = ALUA_PA;
                ALUB_Mux_select      = imm ? ALUB_EXT : ALUB_PB;
                extender_select      = EXT_SIMM13;
                ALU_op               = op3;
                register_file_enable = 1'b1;
                PSR_Enable           = IR_Out[23];
            end
            S_SETHI: begin
                ALUA_Mux_select      = ALUA_ZERO;
                ALUB_Mux_select      = ALUB_EXT;
                extender_select      = EXT_IMM22;
                register_file_enable = 1'b1;
            end
            S_BR: begin
                extender_select = EXT_DISP22;
                if (taken && !annul) begin
                    PC_In_Mux_select = PCIN_NPC;
                    PC_enable        = 1'b1;
                    ALUA_Mux_select  = ALUA_PC;
                    ALUB_Mux_select  = ALUB_EXT;
                    NPC_enable       = 1'b1;
                end else if (taken && annul) begin
                    ALUA_Mux_select  = ALUA_PC;
                    ALUB_Mux_select  = ALUB_EXT;
                    PC_In_Mux_select = PCIN_ALU;
                    PC_enable        = 1'b1;
                end else if (annul) begin
                    ALUA_Mux_select  = ALUA_NPC;
                    ALUB_Mux_select  = ALUB_FOUR;
                    PC_In_Mux_select = PCIN_ALU;
                    PC_enable        = 1'b1;
                end
            end
            S_BR_ANNUL: begin
                ALUA_Mux_select = ALUA_PC;
                ALUB_Mux_select = ALUB_FOUR;
                NPC_enable      = 1'b1;
            end
            S_CALL1: begin
                ALUA_Mux_select      = ALUA_PC;
                ALUB_Mux_select      = ALUB_ZERO;
                in_PC                = REG_LINK;
                register_file_enable = 1'b1;
            end
            S_CALL2: begin
                PC_In_Mux_select = PCIN_NPC;
                PC_enable        = 1'b1;
                ALUA_Mux_select  = ALUA_PC;
                ALUB_Mux_select  = ALUB_EXT;
                extender_select  = EXT_DISP30;
                NPC_enable       = 1'b1;
            end
            S_LS_ADDR: begin
                ALUA_Mux_select = ALUA_PA;
                ALUB_Mux_select = imm ? ALUB_EXT : ALUB_PB;
                extender_select = EXT_SIMM13;
                MAR_Enable      = 1'b1;
            end
            S_LD_MEM: begin
                RAM_enable     = 1'b1;
                RAM_OpCode     = op3;
                MDR_Mux_select = MDR_RAM;
                MDR_Enable     = 1'b1;
            end
            S_LD_WB: begin
                ALUA_Mux_select      = ALUA_ZERO;
                ALUB_Mux_select      = ALUB_MDR;
                register_file_enable = 1'b1;
            end
            S_ST_DATA: begin
                in_PB           = IR_Out[29:25];
                ALUA_Mux_select = ALUA_ZERO;
                ALUB_Mux_select = ALUB_PB;
                MDR_Mux_select  = MDR_ALU;
                MDR_Enable      = 1'b1;
            end
            S_ST_MEM: begin
                RAM_enable = 1'b1;
                RAM_OpCode = OP3_ST;
            end
            S_NEXT_PC: begin
                PC_In_Mux_select = PCIN_NPC;
                PC_enable        = 1'b1;
                ALUA_Mux_select  = ALUA_NPC;
                ALUB_Mux_select  = ALUB_FOUR;
                NPC_enable       = 1'b1;
            end
            S_TRAP: begin
                if (ET) begin
                    tt               = TT_ILLEGAL;
                    TBR_Mux_select   = TBR_MUX_TT;
                    TBR_enable       = 1'b1;
                    PSR_Mux_select   = PSR_MUX_TRAP;
                    PSR_Enable       = 1'b1;
                    PC_In_Mux_select = PCIN_TBR;
                    PC_enable        = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_unit_v2.sv
// Scoreboard bench: each task queues per-cycle stimulus with the expected
// full output vector, then replays the queue comparing at the falling edge.
module tb_control_unit_v2;

    logic        Clk = 1'b0;
    logic        RESET, MFC, MSET, out_BLA, BA_O, BN_O, S, PS, ET;
    logic [31:0] IR_Out;
    logic        IR_enable, PC_enable, NPC_enable, MDR_Enable, MAR_Enable;
    logic        register_file_enable, RAM_enable, PSR_Enable, TBR_enable;
    logic        PC_Clr, PSR_Clr, TBR_Clr, MDR_Mux_select, TBR_Mux_select;
    logic [4:0]  in_PA, in_PB, in_PC;
    logic [5:0]  ALU_op, RAM_OpCode;
    logic [2:0]  tt, extender_select, ALUB_Mux_select;
    logic [1:0]  PC_In_Mux_select, ALUA_Mux_select, PSR_Mux_select;

    int unsigned errors = 0;
    int unsigned checks = 0;

    control_unit_v2 dut (
        .Clk(Clk), .RESET(RESET), .IR_Out(IR_Out), .MFC(MFC), .MSET(MSET),
        .out_BLA(out_BLA), .BA_O(BA_O), .BN_O(BN_O), .S(S), .PS(PS), .ET(ET),
        .IR_enable(IR_enable), .PC_enable(PC_enable), .NPC_enable(NPC_enable),
        .MDR_Enable(MDR_Enable), .MAR_Enable(MAR_Enable),
        .register_file_enable(register_file_enable), .RAM_enable(RAM_enable),
        .PSR_Enable(PSR_Enable), .TBR_enable(TBR_enable),
        .PC_Clr(PC_Clr), .PSR_Clr(PSR_Clr), .TBR_Clr(TBR_Clr),
        .in_PA(in_PA), .in_PB(in_PB), .in_PC(in_PC),
        .ALU_op(ALU_op), .RAM_OpCode(RAM_OpCode), .tt(tt),
        .extender_select(extender_select), .ALUB_Mux_select(ALUB_Mux_select),
        .PC_In_Mux_select(PC_In_Mux_select), .ALUA_Mux_select(ALUA_Mux_select),
        .PSR_Mux_select(PSR_Mux_select), .MDR_Mux_select(MDR_Mux_select),
        .TBR_Mux_select(TBR_Mux_select)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [4:0] state;
        logic       ir_en, pc_en, npc_en, mdr_en, mar_en, rf_en, ram_en, psr_en, tbr_en;
        logic       pc_clr, psr_clr, tbr_clr;
        logic [4:0] pa, pb, pc;
        logic [5:0] alu_op, ram_op;
        logic [2:0] tt, ext, alub;
        logic [1:0] pcin, alua, psrmux;
        logic       mdrmux, tbrmux;
    } obs_t;

    typedef struct {
        string       name;
        logic        chk, rst, mfc, bla, ba, bn, et;
        logic [31:0] ir;
        obs_t        exp;
    } ent_t;

    ent_t sb[$];

    function automatic obs_t snap();
        obs_t o;
        o.state  = dut.state_q;
        o.ir_en  = IR_enable;   o.pc_en  = PC_enable;  o.npc_en = NPC_enable;
        o.mdr_en = MDR_Enable;  o.mar_en = MAR_Enable; o.rf_en  = register_file_enable;
        o.ram_en = RAM_enable;  o.psr_en = PSR_Enable; o.tbr_en = TBR_enable;
        o.pc_clr = PC_Clr;      o.psr_clr = PSR_Clr;   o.tbr_clr = TBR_Clr;
        o.pa = in_PA; o.pb = in_PB; o.pc = in_PC;
        o.alu_op = ALU_op; o.ram_op = RAM_OpCode; o.tt = tt;
        o.ext = extender_select; o.alub = ALUB_Mux_select;
        o.pcin = PC_In_Mux_select; o.alua = ALUA_Mux_select; o.psrmux = PSR_Mux_select;
        o.mdrmux = MDR_Mux_select; o.tbrmux = TBR_Mux_select;
        return o;
    endfunction

    // Entry with every output at its idle value for the given state and IR.
    function automatic ent_t ent(string nm, logic [4:0] st, logic [31:0] ir);
        ent_t e;
        e.name = nm; e.chk = 1'b1; e.rst = 1'b0; e.mfc = 1'b0;
        e.bla = 1'b0; e.ba = 1'b0; e.bn = 1'b0; e.et = 1'b0; e.ir = ir;
        e.exp = '0;
        e.exp.state = st;
        e.exp.pa = ir[18:14]; e.exp.pb = ir[4:0]; e.exp.pc = ir[29:25];
        return e;
    endfunction

    task automatic push_reset(input logic [31:0] ir);
        ent_t e;
        e = ent("reset_in", 5'd0, ir); e.chk = 1'b0; e.rst = 1'b1; sb.push_back(e);
        e = ent("reset0", 5'd0, ir);
        e.exp.pc_clr = 1; e.exp.psr_clr = 1; e.exp.tbr_clr = 1; sb.push_back(e);
        e = ent("init", 5'd1, ir);
        e.exp.npc_en = 1; e.exp.alua = 2'd3; e.exp.alub = 3'd2; sb.push_back(e);
        e = ent("fetch0", 5'd2, ir);
        e.exp.mar_en = 1; e.exp.alua = 2'd1; e.exp.alub = 3'd4; sb.push_back(e);
    endtask

    task automatic push_fetch(input logic [31:0] ir);
        ent_t e;
        push_reset(ir);
        e = ent("fetch1", 5'd3, ir); e.mfc = 1;
        e.exp.ram_en = 1; e.exp.mdr_en = 1; e.exp.mdrmux = 1; sb.push_back(e);
        e = ent("fetch2", 5'd4, ir); e.exp.ir_en = 1; sb.push_back(e);
        e = ent("decode", 5'd5, ir); sb.push_back(e);
    endtask

    task automatic test_reset();
        ent_t e, cur;
        obs_t got;
        logic [31:0] ir = 32'h0;
        e = ent("reset_in", 5'd0, ir); e.chk = 1'b0; e.rst = 1'b1; sb.push_back(e);
        e = ent("reset_hold", 5'd0, ir); e.rst = 1'b1;
        e.exp.pc_clr = 1; e.exp.psr_clr = 1; e.exp.tbr_clr = 1; sb.push_back(e);
        push_reset(ir);
        while (sb.size() > 0) begin
            cur = sb.pop_front();
            RESET = cur.rst; MFC = cur.mfc; out_BLA = cur.bla; BA_O = cur.ba;
            BN_O = cur.bn; ET = cur.et; IR_Out = cur.ir;
            @(negedge Clk);
            if (cur.chk) begin
                checks++; got = snap();
                if (got !== cur.exp) begin
                    errors++; $display("FAIL %s: got=%h want=%h", cur.name, got, cur.exp);
                end
            end
            @(posedge Clk); #1;
        end
    endtask

    task automatic test_fetch_wait();
        ent_t e, cur;
        obs_t got;
        logic [31:0] ir = 32'hDEADBEEF;
        push_reset(ir);
        for (int i = 0; i < 3; i++) begin
            e = ent("fetch1_wait", 5'd3, ir);
            e.exp.ram_en = 1; e.exp.mdr_en = 1; e.exp.mdrmux = 1; sb.push_back(e);
        end
        e = ent("fetch1_mfc", 5'd3, ir); e.mfc = 1;
        e.exp.ram_en = 1; e.exp.mdr_en = 1; e.exp.mdrmux = 1; sb.push_back(e);
        e = ent("fetch2", 5'd4, ir); e.exp.ir_en = 1; sb.push_back(e);
        while (sb.size() > 0) begin
            cur = sb.pop_front();
            RESET = cur.rst; MFC = cur.mfc; out_BLA = cur.bla; BA_O = cur.ba;
            BN_O = cur.bn; ET = cur.et; IR_Out = cur.ir;
            @(negedge Clk);
            if (cur.chk) begin
                checks++; got = snap();
                if (got !== cur.exp) begin
                    errors++; $display("FAIL %s: got=%h want=%h", cur.name, got, cur.exp);
                end
            end
            @(posedge Clk); #1;
        end
    endtask

    task automatic test_arith_sethi_call();
        ent_t e, cur;
        obs_t got;
        logic [31:0] ir;
        ir = 32'h86004002;
        push_fetch(ir);
        e = ent("arith_add", 5'd6, ir); e.exp.rf_en = 1; sb.push_back(e);
        e = ent("next_pc", 5'd17, ir);
        e.exp.pc_en = 1; e.exp.npc_en = 1; e.exp.alua = 2'd2; e.exp.alub = 3'd2; sb.push_back(e);
        e = ent("after_next", 5'd2, ir);
        e.exp.mar_en = 1; e.exp.alua = 2'd1; e.exp.alub = 3'd4; sb.push_back(e);
        ir = {2'b10, 5'd4, 6'b010100, 5'd1, 1'b1, 13'd5};
        push_fetch(ir);
        e = ent("arith_subcc_imm", 5'd6, ir);
        e.exp.rf_en = 1; e.exp.alu_op = 6'b010100; e.exp.alub = 3'd1; e.exp.psr_en = 1;
        sb.push_back(e);
        ir = {2'b00, 5'd6, 3'b100, 22'h12345};
        push_fetch(ir);
        e = ent("sethi", 5'd7, ir);
        e.exp.rf_en = 1; e.exp.alua = 2'd3; e.exp.alub = 3'd1; e.exp.ext = 3'd3; sb.push_back(e);
        e = ent("sethi_next", 5'd17, ir);
        e.exp.pc_en = 1; e.exp.npc_en = 1; e.exp.alua = 2'd2; e.exp.alub = 3'd2; sb.push_back(e);
        ir = {2'b01, 30'd7};
        push_fetch(ir);
        e = ent("call1", 5'd10, ir);
        e.exp.rf_en = 1; e.exp.pc = 5'd15; e.exp.alua = 2'd1; e.exp.alub = 3'd4; sb.push_back(e);
        e = ent("call2", 5'd11, ir);
        e.exp.pc_en = 1; e.exp.npc_en = 1; e.exp.alua = 2'd1; e.exp.alub = 3'd1; e.exp.ext = 3'd2;
        sb.push_back(e);
        e = ent("call_fetch0", 5'd2, ir);
        e.exp.mar_en = 1; e.exp.alua = 2'd1; e.exp.alub = 3'd4; sb.push_back(e);
        while (sb.size() > 0) begin
            cur = sb.pop_front();
            RESET = cur.rst; MFC = cur.mfc; out_BLA = cur.bla; BA_O = cur.ba;
            BN_O = cur.bn; ET = cur.et; IR_Out = cur.ir;
            @(negedge Clk);
            if (cur.chk) begin
                checks++; got = snap();
                if (got !== cur.exp) begin
                    errors++; $display("FAIL %s: got=%h want=%h", cur.name, got, cur.exp);
                end
            end
            @(posedge Clk); #1;
        end
    endtask

    task automatic test_branch();
        ent_t e, cur;
        obs_t got;
        logic [31:0] ir;
        // BA, a=0: taken without annul
        ir = {2'b00, 1'b0, 4'b1000, 3'b010, 22'd3};
        push_fetch(ir);
        e = ent("ba_a0", 5'd8, ir); e.ba = 1;
        e.exp.ext = 3'd1; e.exp.pc_en = 1; e.exp.npc_en = 1; e.exp.alua = 2'd1; e.exp.alub = 3'd1;
        sb.push_back(e);
        e = ent("ba_a0_fetch0", 5'd2, ir);
        e.exp.mar_en = 1; e.exp.alua = 2'd1; e.exp.alub = 3'd4; sb.push_back(e);
        // BNE, a=1, condition false
        ir = {2'b00, 1'b1, 4'b1001, 3'b010, 22'h3FFFF0};
        push_fetch(ir);
        e = ent("bne_a1_nt", 5'd8, ir);
        e.exp.ext = 3'd1; e.exp.pc_en = 1; e.exp.pcin = 2'd1; e.exp.alua = 2'd2; e.exp.alub = 3'd2;
        sb.push_back(e);
        e = ent("br_annul", 5'd9, ir);
        e.exp.npc_en = 1; e.exp.alua = 2'd1; e.exp.alub = 3'd2; sb.push_back(e);
        e = ent("annul_fetch0", 5'd2, ir);
        e.exp.mar_en = 1; e.exp.alua = 2'd1; e.exp.alub = 3'd4; sb.push_back(e);
        // BA, a=1: taken with annul
        ir = {2'b00, 1'b1, 4'b1000, 3'b010, 22'd9};
        push_fetch(ir);
        e = ent("ba_a1", 5'd8, ir); e.ba = 1;
        e.exp.ext = 3'd1; e.exp.pc_en = 1; e.exp.pcin = 2'd1; e.exp.alua = 2'd1; e.exp.alub = 3'd1;
        sb.push_back(e);
        e = ent("ba_a1_annul", 5'd9, ir);
        e.exp.npc_en = 1; e.exp.alua = 2'd1; e.exp.alub = 3'd2; sb.push_back(e);
        // BNE, a=0, out_BLA true but BN_O overrides: not taken, no annul
        ir = {2'b00, 1'b0, 4'b1001, 3'b010, 22'd1};
        push_fetch(ir);
        e = ent("bn_override", 5'd8, ir); e.bla = 1; e.bn = 1; e.exp.ext = 3'd1; sb.push_back(e);
        e = ent("bn_next_pc", 5'd17, ir);
        e.exp.pc_en = 1; e.exp.npc_en = 1; e.exp.alua = 2'd2; e.exp.alub = 3'd2; sb.push_back(e);
        while (sb.size() > 0) begin
            cur = sb.pop_front();
            RESET = cur.rst; MFC = cur.mfc; out_BLA = cur.bla; BA_O = cur.ba;
            BN_O = cur.bn; ET = cur.et; IR_Out = cur.ir;
            @(negedge Clk);
            if (cur.chk) begin
                checks++; got = snap();
                if (got !== cur.exp) begin
                    errors++; $display("FAIL %s: got=%h want=%h", cur.name, got, cur.exp);
                end
            end
            @(posedge Clk); #1;
        end
    endtask

    task automatic test_load_store();
        ent_t e, cur;
        obs_t got;
        logic [31:0] ir;
        ir = {2'b11, 5'd7, 6'b000000, 5'd2, 1'b1, 13'd8};
        push_fetch(ir);
        e = ent("ld_addr", 5'd12, ir);
        e.exp.mar_en = 1; e.exp.alub = 3'd1; sb.push_back(e);
        for (int i = 0; i < 2; i++) begin
            e = ent("ld_mem_wait", 5'd13, ir);
            e.exp.ram_en = 1; e.exp.mdr_en = 1; e.exp.mdrmux = 1; sb.push_back(e);
        end
        e = ent("ld_mem_mfc", 5'd13, ir); e.mfc = 1;
        e.exp.ram_en = 1; e.exp.mdr_en = 1; e.exp.mdrmux = 1; sb.push_back(e);
        e = ent("ld_wb", 5'd14, ir);
        e.exp.rf_en = 1; e.exp.alua = 2'd3; e.exp.alub = 3'd3; sb.push_back(e);
        e = ent("ld_next_pc", 5'd17, ir);
        e.exp.pc_en = 1; e.exp.npc_en = 1; e.exp.alua = 2'd2; e.exp.alub = 3'd2; sb.push_back(e);
        ir = {2'b11, 5'd9, 6'b000100, 5'd2, 1'b0, 8'd0, 5'd4};
        push_fetch(ir);
        e = ent("st_addr", 5'd12, ir); e.exp.mar_en = 1; sb.push_back(e);
        e = ent("st_data", 5'd15, ir);
        e.exp.pb = 5'd9; e.exp.alua = 2'd3; e.exp.mdr_en = 1; sb.push_back(e);
        e = ent("st_mem_wait", 5'd16, ir);
        e.exp.ram_en = 1; e.exp.ram_op = 6'b000100; sb.push_back(e);
        e = ent("st_mem_mfc", 5'd16, ir); e.mfc = 1;
        e.exp.ram_en = 1; e.exp.ram_op = 6'b000100; sb.push_back(e);
        e = ent("st_next_pc", 5'd17, ir);
        e.exp.pc_en = 1; e.exp.npc_en = 1; e.exp.alua = 2'd2; e.exp.alub = 3'd2; sb.push_back(e);
        // reset while a load is still waiting on memory
        ir = {2'b11, 5'd3, 6'b000000, 5'd1, 1'b0, 8'd0, 5'd2};
        push_fetch(ir);
        e = ent("ld_addr_rr", 5'd12, ir); e.exp.mar_en = 1; sb.push_back(e);
        e = ent("ld_wait_rst", 5'd13, ir); e.rst = 1;
        e.exp.ram_en = 1; e.exp.mdr_en = 1; e.exp.mdrmux = 1; sb.push_back(e);
        e = ent("midwait_reset0", 5'd0, ir);
        e.exp.pc_clr = 1; e.exp.psr_clr = 1; e.exp.tbr_clr = 1; sb.push_back(e);
        while (sb.size() > 0) begin
            cur = sb.pop_front();
            RESET = cur.rst; MFC = cur.mfc; out_BLA = cur.bla; BA_O = cur.ba;
            BN_O = cur.bn; ET = cur.et; IR_Out = cur.ir;
            @(negedge Clk);
            if (cur.chk) begin
                checks++; got = snap();
                if (got !== cur.exp) begin
                    errors++; $display("FAIL %s: got=%h want=%h", cur.name, got, cur.exp);
                end
            end
            @(posedge Clk); #1;
        end
    endtask

    task automatic test_trap();
        ent_t e, cur;
        obs_t got;
        logic [31:0] ir;
        ir = {2'b00, 5'd0, 3'b000, 22'd0};
        push_fetch(ir);
        e = ent("trap_et1", 5'd18, ir); e.et = 1;
        e.exp.tt = 3'b010; e.exp.tbrmux = 1; e.exp.tbr_en = 1; e.exp.psrmux = 2'd1;
        e.exp.psr_en = 1; e.exp.pcin = 2'd2; e.exp.pc_en = 1; sb.push_back(e);
        e = ent("trap_annul", 5'd9, ir);
        e.exp.npc_en = 1; e.exp.alua = 2'd1; e.exp.alub = 3'd2; sb.push_back(e);
        ir = {2'b11, 5'd1, 6'b000001, 5'd1, 1'b0, 13'd0};
        push_fetch(ir);
        e = ent("trap_bad_op3", 5'd18, ir); e.et = 1;
        e.exp.tt = 3'b010; e.exp.tbrmux = 1; e.exp.tbr_en = 1; e.exp.psrmux = 2'd1;
        e.exp.psr_en = 1; e.exp.pcin = 2'd2; e.exp.pc_en = 1; sb.push_back(e);
        ir = {2'b00, 5'd0, 3'b000, 22'd0};
        push_fetch(ir);
        e = ent("trap_et0", 5'd18, ir); sb.push_back(e);
        for (int i = 0; i < 4; i++) begin
            e = ent("halt_hold", 5'd19, ir); e.mfc = 1; e.et = 1; sb.push_back(e);
        end
        e = ent("halt_rst", 5'd19, ir); e.rst = 1; sb.push_back(e);
        e = ent("halt_reset0", 5'd0, ir);
        e.exp.pc_clr = 1; e.exp.psr_clr = 1; e.exp.tbr_clr = 1; sb.push_back(e);
        while (sb.size() > 0) begin
            cur = sb.pop_front();
            RESET = cur.rst; MFC = cur.mfc; out_BLA = cur.bla; BA_O = cur.ba;
            BN_O = cur.bn; ET = cur.et; IR_Out = cur.ir;
            @(negedge Clk);
            if (cur.chk) begin
                checks++; got = snap();
                if (got !== cur.exp) begin
                    errors++; $display("FAIL %s: got=%h want=%h", cur.name, got, cur.exp);
                end
            end
            @(posedge Clk); #1;
        end
    endtask

    initial begin
        RESET = 1'b1; MFC = 1'b0; MSET = 1'b0; out_BLA = 1'b0; BA_O = 1'b0;
        BN_O = 1'b0; S = 1'b0; PS = 1'b0; ET = 1'b0; IR_Out = '0;
        repeat (2) @(posedge Clk);
        #1;
        test_reset();
        test_fetch_wait();
        test_arith_sethi_call();
        test_branch();
        test_load_store();
        test_trap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
